// File: rtl/pwm_multi_ch.sv
// N-channel edge-aligned PWM with shared prescaler/counter and shadowed duty words.
// Shadow duties move to the active set only at a period wrap, or continuously while disabled.
module pwm_multi_ch #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned RES    = 8,
  parameter int unsigned DVSR_W = 16,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DVSR_W-1:0] i_dvsr,
  input  logic              i_wr,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [RES:0]      i_wr_duty,
  output logic [N_CH-1:0]   o_pwm,
  output logic              o_period
);

  localparam logic [RES:0] FULL = {1'b1, {RES{1'b0}}};

  logic [DVSR_W-1:0] pre_q, pre_d;
  logic [RES-1:0]    cnt_q, cnt_d;
  logic [RES:0]      shd_q [N_CH];
  logic [RES:0]      shd_d [N_CH];
  logic [RES:0]      act_q [N_CH];
  logic [RES:0]      act_d [N_CH];
  logic [N_CH-1:0]   pwm_q, pwm_d;
  logic              period_q, period_d;
  logic              step, wrap;
  logic [RES:0]      duty_clamped;

  assign step         = i_en && (pre_q == i_dvsr);
  assign wrap         = step && (cnt_q == '1);
  assign duty_clamped = (i_wr_duty > FULL) ? FULL : i_wr_duty;

  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    shd_d    = shd_q;
    act_d    = act_q;
    pwm_d    = '0;
    period_d = 1'b0;
    if (!i_en) begin
      pre_d = '0;
      cnt_d = '0;
      act_d = shd_q;
    end else begin
      // pre_q above a lowered i_dvsr keeps counting and wraps naturally
      pre_d = step ? '0 : pre_q + DVSR_W'(1);
      if (step) cnt_d = cnt_q + RES'(1);
      if (wrap) act_d = shd_q;
      period_d = wrap;
      for (int unsigned k = 0; k < N_CH; k++)
        pwm_d[k] = ({1'b0, cnt_q} < act_q[k]);
    end
    // shadow update reads as a plain overwrite; active copies above see pre-write values
    for (int unsigned k = 0; k < N_CH; k++)
      if (i_wr && (i_wr_ch == CH_W'(k))) shd_d[k] = duty_clamped;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      pwm_q    <= '0;
      period_q <= 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        shd_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      period_q <= period_d;
      shd_q    <= shd_d;
      act_q    <= act_d;
    end
  end

  assign o_pwm    = pwm_q;
  assign o_period = period_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized bench for pwm_multi_ch (N_CH=3, RES=4) against a time-based reference model.
module tb_pwm_multi_ch;

  localparam int N   = 3;
  localparam int RES = 4;
  localparam int P   = 1 << RES;

  logic       clk = 1'b0;
  logic       rst, en, wr;
  logic [7:0] dvsr;
  logic [1:0] wr_ch;
  logic [4:0] wr_duty;
  logic [N-1:0] pwm;
  logic       period;

  pwm_multi_ch #(.N_CH(N), .RES(RES), .DVSR_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_dvsr(dvsr),
    .i_wr(wr), .i_wr_ch(wr_ch), .i_wr_duty(wr_duty),
    .o_pwm(pwm), .o_period(period)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference: position in the period derived from clocks elapsed since enable.
  int unsigned m_t;
  int          m_shd [N];
  int          m_act [N];
  logic [N-1:0] e_pwm;
  logic        e_per;

  function automatic bit model_wrap_next();
    int d = int'(dvsr) + 1;
    return en && (((m_t + 1) % (P * d)) == 0);
  endfunction

  task automatic model_edge();
    int d, pos;
    bit w;
    if (rst) begin
      m_t = 0; e_pwm = '0; e_per = 1'b0;
      for (int k = 0; k < N; k++) begin m_shd[k] = 0; m_act[k] = 0; end
      return;
    end
    d   = int'(dvsr) + 1;
    pos = (m_t / d) % P;
    w   = model_wrap_next();
    if (en) begin
      for (int k = 0; k < N; k++) e_pwm[k] = (pos < m_act[k]);
      e_per = w;
      if (w) for (int k = 0; k < N; k++) m_act[k] = m_shd[k];
      m_t++;
    end else begin
      e_pwm = '0; e_per = 1'b0; m_t = 0;
      for (int k = 0; k < N; k++) m_act[k] = m_shd[k];
    end
    if (wr && int'(wr_ch) < N) m_shd[wr_ch] = (int'(wr_duty) > P) ? P : int'(wr_duty);
  endtask

  int dvsr_tab [8] = '{0, 2, 1, 0, 3, 0, 2, 0};
  int off_left;
  int pick;

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; dvsr = '0; wr_ch = '0; wr_duty = '0;
    off_left = 0;
    @(negedge clk);
    @(posedge clk); model_edge(); #1;
    check("reset_pwm", int'(pwm), 0);
    check("reset_period", int'(period), 0);
    @(negedge clk);

    for (int c = 0; c < 4000; c++) begin
      rst = (c < 2) || ($urandom_range(0, 599) == 0);
      wr  = 1'b0;
      if ((c % 500) < 3) begin
        en   = 1'b0;
        dvsr = 8'(dvsr_tab[c / 500]);
      end else begin
        if (off_left > 0) off_left--;
        else if ($urandom_range(0, 199) == 0) off_left = $urandom_range(1, 6);
        en = (off_left == 0);
        if ($urandom_range(0, 29) == 0 || (model_wrap_next() && $urandom_range(0, 3) == 0)) begin
          wr    = 1'b1;
          wr_ch = 2'($urandom_range(0, 3));
          pick  = $urandom_range(0, 5);
          wr_duty = (pick == 0) ? 5'd0 : (pick == 1) ? 5'd16 :
                    (pick == 2) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(1, 15));
        end
      end
      @(posedge clk); model_edge(); #1;
      check("pwm", int'(pwm), int'(e_pwm));
      check("period", int'(period), int'(e_per));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
